if_id_skid_stage: RTL and testbench
===================================

# if_id_skid_stage

- Parametrised IF→ID pipeline stage register; replaces the fixed 32-bit CE-gated stage.
- Carries {PC, instruction} under a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput under back-pressure.
- Adds a synchronous flush that inserts a NOP bubble, and a saturating stall counter for performance debug.

## Interface

Parameters:

- `PC_W`, 32, PC field width
- `INST_W`, 32, instruction field width
- `NOP_INST`, `32'h0000_0000` (`INST_W` bits), instruction value presented when the stage holds no valid entry
- `RESET_PC`, `32'h0000_0000` (`PC_W` bits), PC value after reset or flush
- `CNT_W`, 16, stall counter width

Ports:

- `clk` — input, 1 — single clock; all state updates on its rising edge
- `rst` — input, 1 — reset, asynchronous, active-high
- `flush` — input, 1 — synchronous flush (branch/exception redirect)
- `in_valid` — input, 1 — IF presents an entry
- `in_ready` — output, 1 — stage can accept an entry
- `in_pc` — input, `PC_W` — IF PC
- `in_inst` — input, `INST_W` — fetched instruction
- `out_valid` — output, 1 — ID-side entry valid
- `out_ready` — input, 1 — ID consumes the entry
- `out_pc` — output, `PC_W` — ID PC
- `out_inst` — output, `INST_W` — ID instruction
- `occupancy` — output, 2 — number of held entries (0..2)
- `stall_cnt` — output, `CNT_W` — saturating count of stalled cycles

## Operation

- Storage:
  - The main register (`out_pc`/`out_inst`) drives the outputs directly.
  - There is one skid register.
  - All outputs are registered or decoded from the state register only; there is no combinational path from `in_*` to `out_*`.
- Fire conditions:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
- State machine:
  - EMPTY (occupancy 0): `out_valid=0`, `in_ready=1`.
  - ONE (occupancy 1): `out_valid=1`, `in_ready=1`.
  - FULL (occupancy 2): `out_valid=1`, `in_ready=0`.
- Transitions (when `flush=0`):
  - EMPTY, `in_fire` → ONE; main ← in.
  - ONE, `in_fire & out_fire` → ONE; main ← in.
  - ONE, `in_fire` only → FULL; skid ← in; main holds.
  - ONE, `out_fire` only → EMPTY; `out_inst` ← `NOP_INST`; `out_pc` holds.
  - FULL, `out_fire` → ONE; main ← skid.
  - Any other case: hold all registers.
- Ordering: entries leave in exact arrival order, and none is dropped or duplicated except by flush.
- `flush=1` has highest priority below reset:
  - Next state is EMPTY.
  - `out_inst` ← `NOP_INST`; `out_pc` ← `RESET_PC`.
  - The skid register contents are discarded.
  - Any `in_fire` in the same cycle is discarded.
  - An `out_fire` in the same cycle still counts as consumed by ID.
- `stall_cnt`:
  - Increments by 1 on every cycle with `out_valid & ~out_ready`.
  - Saturates at 2^`CNT_W`−1.
  - Cleared only by `rst`; flush does not clear it.
- When `out_valid=0`, `out_inst` always equals `NOP_INST`, so a downstream decoder ignoring `out_valid` sees a bubble.

## Timing

- Reset (async assert, released synchronously by the system):
  - State EMPTY; `out_valid=0`, `in_ready=1`, `occupancy=0`.
  - `out_pc=RESET_PC`, `out_inst=NOP_INST`, skid=0, `stall_cnt=0`.
- Latency: an entry accepted at edge N is visible on `out_*` with `out_valid=1` after edge N (one cycle).
- Throughput: one entry per cycle while `out_ready=1`.
- Back-pressure:
  - After `out_ready` drops, the stage absorbs exactly one more entry (skid).
  - `in_ready` deasserts the following cycle.
  - `in_ready` depends only on state, never combinationally on `out_ready`.
- Refill from FULL:
  - On `out_fire` in FULL, the skid entry appears on `out_*` the next cycle.
  - `in_ready` reasserts that same next cycle.
- Flush: takes effect at the next edge; `out_valid=0` and `in_ready=1` on the following cycle.
- Reset mid-transfer: any held entries are lost; there is no partial update.

## Test plan

1. Reset then stream:
   - Stimulus: hold `rst` 3 cycles; then `in_valid=1` with PCs 0x0, 0x4, 0x8, 0xC, `out_ready=1`.
   - Required: `out_pc` 0x0, 0x4, 0x8, 0xC on consecutive cycles, each one cycle after input; `occupancy` stays 1; `stall_cnt=0`.
2. Back-pressure / skid:
   - Stimulus: stream PCs 0x10, 0x14, 0x18; drop `out_ready` when 0x10 is on the output.
   - Required: 0x14 is captured in skid, `occupancy=2`, `in_ready=0`, 0x18 is held by the source.
   - Then raise `out_ready`: outputs 0x10, 0x14, 0x18 in order with no loss; `stall_cnt` equals the stalled cycle count.
3. Flush while FULL:
   - Stimulus: in FULL, assert `flush` together with `in_valid` carrying PC 0x40.
   - Required next cycle: `out_valid=0`, `out_inst=NOP_INST`, `out_pc=RESET_PC`, `occupancy=0`; 0x40 is never output.
4. Drain to empty:
   - Stimulus: single entry PC 0x20, inst 0x1234_5678, consumed with no follow-up input.
   - Required next cycle: `out_valid=0`, `out_inst=NOP_INST`, `out_pc` remains 0x20.
5. Stall counter saturation:
   - Stimulus: `CNT_W=3`, hold `out_valid` with `out_ready=0` for 10 cycles.
   - Required: `stall_cnt` counts 1..7, then stays 7.
6. Asynchronous reset mid-stream:
   - Stimulus: assert `rst` between clock edges while FULL.
   - Required: outputs immediately return to reset values without waiting for `clk`.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF->ID valid/ready stage register with a 2-entry skid, flush-to-bubble and stall counter
module if_id_skid_stage #(
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] inst_q, inst_d, skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic in_fire, out_fire;
  // state encoding equals occupancy, so handshake outputs decode straight from the state register
  assign in_ready = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign occupancy = state_q;
  assign out_pc = pc_q;
  assign out_inst = inst_q;
  assign stall_cnt = cnt_q;
  always_comb begin
    in_fire = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    skid_pc_d = skid_pc_q;
    skid_inst_d = skid_inst_q;
    cnt_d = (out_valid & ~out_ready & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    if (flush) begin
      state_d = EMPTY;
      pc_d = RESET_PC;
      inst_d = NOP_INST;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = ONE;
          pc_d = in_pc;
          inst_d = in_inst;
        end
        ONE: if (in_fire & out_fire) begin
          pc_d = in_pc;
          inst_d = in_inst;
        end else if (in_fire) begin
          state_d = FULL;
          skid_pc_d = in_pc;
          skid_inst_d = in_inst;
        end else if (out_fire) begin
          state_d = EMPTY;
          inst_d = NOP_INST;
        end
        FULL: if (out_fire) begin
          state_d = ONE;
          pc_d = skid_pc_q;
          inst_d = skid_inst_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      pc_q <= RESET_PC;
      inst_q <= NOP_INST;
      skid_pc_q <= '0;
      skid_inst_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      skid_pc_q <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb_if_id_skid_stage: directed and random checks of the IF->ID skid stage against a queue model
module tb_if_id_skid_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_inst = 0;
  logic in_ready, out_valid, in_ready3, out_valid3;
  logic [31:0] out_pc, out_inst, out_pc3, out_inst3;
  logic [1:0] occupancy, occupancy3;
  logic [15:0] stall_cnt;
  logic [2:0] stall_cnt3;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t q[$];
  logic [31:0] hold_pc;
  int cnt16, cnt3;

  always #5 clk = ~clk;

  if_id_skid_stage #(.NOP_INST(NOP), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .occupancy(occupancy), .stall_cnt(stall_cnt));

  if_id_skid_stage #(.NOP_INST(NOP), .RESET_PC(RPC), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid3), .out_ready(out_ready),
    .out_pc(out_pc3), .out_inst(out_inst3), .occupancy(occupancy3), .stall_cnt(stall_cnt3));

  task automatic model_reset();
    q.delete();
    hold_pc = RPC;
    cnt16 = 0;
    cnt3 = 0;
  endtask

  // transaction-level view: a FIFO of up to two entries, stalls counted when the head waits
  task automatic model_step();
    bit ov, ir;
    ov = q.size() > 0;
    ir = q.size() < 2;
    if (ov && !out_ready) begin
      cnt16 = (cnt16 < 65535) ? cnt16 + 1 : cnt16;
      cnt3 = (cnt3 < 7) ? cnt3 + 1 : cnt3;
    end
    if (flush) begin
      q.delete();
      hold_pc = RPC;
    end else begin
      if (ov && out_ready) begin
        hold_pc = q[0].pc;
        void'(q.pop_front());
      end
      if (in_valid && ir) q.push_back('{in_pc, in_inst});
    end
  endtask

  function automatic logic [31:0] e_pc();
    return q.size() > 0 ? q[0].pc : hold_pc;
  endfunction
  function automatic logic [31:0] e_inst();
    return q.size() > 0 ? q[0].inst : NOP;
  endfunction

  task automatic tick(input logic v, input logic [31:0] p, input logic [31:0] i, input logic r, input logic f);
    in_valid = v;
    in_pc = p;
    in_inst = i;
    out_ready = r;
    flush = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    total += 6;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    if (out_pc !== RPC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", out_pc, RPC); end
    if (out_inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h exp=%h", out_inst, NOP); end
    if (stall_cnt !== 16'd0 || stall_cnt3 !== 3'd0) begin bad++; $display("FAIL reset_stall got=%0d/%0d exp=0", stall_cnt, stall_cnt3); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 4; k++) begin
      tick(1, 32'(k * 4), 32'hA000_0000 + 32'(k), 1, 0);
      total += 4;
      if (out_pc !== 32'(k * 4)) begin bad++; $display("FAIL stream_pc got=%h exp=%h", out_pc, k * 4); end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%b exp=1", out_valid); end
      if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ got=%0d exp=1", occupancy); end
      if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_skid();
    logic [31:0] exp_seq [3] = '{32'h14, 32'h18, 32'h18};
    tick(1, 32'h10, 32'hB010, 1, 0);
    total++;
    if (out_pc !== 32'h10) begin bad++; $display("FAIL skid_first got=%h exp=10", out_pc); end
    tick(1, 32'h14, 32'hB014, 0, 0);
    repeat (2) tick(1, 32'h18, 32'hB018, 0, 0);
    total += 4;
    if (occupancy !== 2'd2) begin bad++; $display("FAIL skid_occ got=%0d exp=2", occupancy); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_ready got=%b exp=0", in_ready); end
    if (out_pc !== 32'h10) begin bad++; $display("FAIL skid_hold got=%h exp=10", out_pc); end
    if (stall_cnt !== 16'd3) begin bad++; $display("FAIL skid_stall got=%0d exp=3", stall_cnt); end
    for (int k = 0; k < 3; k++) begin
      tick(k < 2, 32'h18, 32'hB018, 1, 0);
      total++;
      if (out_pc !== exp_seq[k]) begin bad++; $display("FAIL skid_order got=%h exp=%h", out_pc, exp_seq[k]); end
    end
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_drain got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL skid_refill got=%b exp=1", in_ready); end
  endtask

  task automatic test_flush();
    tick(1, 32'h30, 32'hC030, 0, 0);
    tick(1, 32'h34, 32'hC034, 0, 0);
    total++;
    if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_full got=%0d exp=2", occupancy); end
    tick(1, 32'h40, 32'hC040, 0, 1);
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    if (out_inst !== NOP) begin bad++; $display("FAIL flush_inst got=%h exp=%h", out_inst, NOP); end
    if (out_pc !== RPC) begin bad++; $display("FAIL flush_pc got=%h exp=%h", out_pc, RPC); end
    if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    repeat (2) begin
      tick(0, 0, 0, 1, 0);
      total++;
      if (out_valid !== 1'b0 || out_pc === 32'h40) begin bad++; $display("FAIL flush_leak got=%b/%h exp=0/-", out_valid, out_pc); end
    end
  endtask

  task automatic test_drain();
    tick(1, 32'h20, 32'h1234_5678, 1, 0);
    total++;
    if (out_inst !== 32'h1234_5678) begin bad++; $display("FAIL drain_inst_in got=%h exp=12345678", out_inst); end
    tick(0, 0, 0, 1, 0);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    if (out_inst !== NOP) begin bad++; $display("FAIL drain_inst got=%h exp=%h", out_inst, NOP); end
    if (out_pc !== 32'h20) begin bad++; $display("FAIL drain_pc got=%h exp=20", out_pc); end
  endtask

  task automatic test_saturate();
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    tick(1, 32'h60, 32'hD060, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 0, 0, 0);
      total += 2;
      if (stall_cnt3 !== 3'((k > 7) ? 7 : k)) begin bad++; $display("FAIL sat_cnt3 got=%0d exp=%0d", stall_cnt3, (k > 7) ? 7 : k); end
      if (stall_cnt !== 16'(k)) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=%0d", stall_cnt, k); end
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
      total += 7;
      if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid got=%b exp=%b", out_valid, q.size() > 0); end
      if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready got=%b exp=%b", in_ready, q.size() < 2); end
      if (occupancy !== 2'(q.size())) begin bad++; $display("FAIL rnd_occ got=%0d exp=%0d", occupancy, q.size()); end
      if (out_pc !== e_pc()) begin bad++; $display("FAIL rnd_pc got=%h exp=%h", out_pc, e_pc()); end
      if (out_inst !== e_inst()) begin bad++; $display("FAIL rnd_inst got=%h exp=%h", out_inst, e_inst()); end
      if (stall_cnt !== 16'(cnt16)) begin bad++; $display("FAIL rnd_stall got=%0d exp=%0d", stall_cnt, cnt16); end
      if (stall_cnt3 !== 3'(cnt3)) begin bad++; $display("FAIL rnd_stall3 got=%0d exp=%0d", stall_cnt3, cnt3); end
    end
  endtask

  task automatic test_async_reset();
    tick(1, 32'h50, 32'hE050, 0, 0);
    tick(1, 32'h54, 32'hE054, 0, 0);
    total++;
    if (occupancy !== 2'd2) begin bad++; $display("FAIL ares_full got=%0d exp=2", occupancy); end
    #2 rst = 1;
    #1;
    total += 4;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ares_hs got=%b/%b exp=0/1", out_valid, in_ready); end
    if (occupancy !== 2'd0) begin bad++; $display("FAIL ares_occ got=%0d exp=0", occupancy); end
    if (out_pc !== RPC || out_inst !== NOP) begin bad++; $display("FAIL ares_data got=%h/%h exp=%h/%h", out_pc, out_inst, RPC, NOP); end
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL ares_stall got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    rst = 0;
    model_reset();
    tick(0, 0, 0, 1, 0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ares_after got=%b exp=0", out_valid); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_drain();
    test_saturate();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
